mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter WID_MEM, default 16, data width of the shared memory.
REQ-002 Parameter DEPTH_MEM, default 1024, number of valid words; addresses >= DEPTH_MEM are out of range.
REQ-003 Port clk  in  1  single clock; all state on its rising edge.
REQ-004 Port reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port req_valid[1:0]  in  2  per-requester request valid.
REQ-006 Port req_ready[1:0]  out  2  per-requester accept; a request transfers when valid && ready in the same cycle.
REQ-007 Port req_we[1:0]  in  2  per-requester: 1 = write, 0 = read.
REQ-008 Port req_addr[1:0]  in  2x32  per-requester word address.
REQ-009 Port req_wdata[1:0]  in  2xWID_MEM  per-requester write data.
REQ-010 Port rsp_valid[1:0]  out  2  per-requester read-data valid pulse.
REQ-011 Port rsp_rdata  out  WID_MEM  read data, qualified by rsp_valid.
REQ-012 Port rsp_err[1:0]  out  2  per-requester out-of-range flag, pulses with rsp_valid (reads) or one cycle after acceptance (writes).
REQ-013 Port mem_raddr  out  32  memory read address.
REQ-014 Port mem_waddr  out  32  memory write address.
REQ-015 Port mem_we  out  1  memory write enable.
REQ-016 Port mem_din  out  WID_MEM  memory write data.
REQ-017 Port mem_dout  in  WID_MEM  memory read data, valid one cycle after mem_raddr.

Function
REQ-018 Read port and write port SHALL be arbitrated independently: at most one read grant and one write grant per cycle, possibly to different requesters.
REQ-019 Each port SHALL use a 1-bit round-robin pointer; on contention, grant the requester the pointer names, then point at the other; without contention, grant the sole requester, pointer unchanged.
REQ-020 req_ready[i] SHALL be combinational: 1 iff requester i wins its port this cycle; asserted while req_valid[i] is low only when no other requester contends for that port.
REQ-021 Accepted write: mem_we=1, mem_waddr=addr, mem_din=wdata in the same cycle; mem_we=0 on all other cycles.
REQ-022 Accepted read: mem_raddr=addr same cycle; rsp_valid[i]=1 and rsp_rdata=mem_dout exactly one cycle later (latency 1, back-to-back reads at full rate).
REQ-023 Out-of-range write: accepted, mem_we held 0, rsp_err[i] pulsed next cycle.
REQ-024 Out-of-range read: accepted, rsp_rdata=0, rsp_valid[i]=1 and rsp_err[i]=1 next cycle.
REQ-025 Simultaneous read and write to the same address: read returns pre-write data (read-first).
REQ-026 When no read is granted, mem_raddr SHALL hold its last value; rsp_rdata SHALL be 0 when no rsp_valid is set.

Reset
REQ-027 On reset_n low: both pointers -> requester 0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_raddr=mem_waddr=0, mem_din=0, stats counters=0; req_ready=0 while reset_n low.
REQ-028 A read accepted in the cycle reset asserts SHALL produce no response after release.

Configuration
REQ-029 Macro MEM_ARB_STATS_EN: when defined, add outputs grant_cnt[1:0] (2x16), per-requester accepted-transaction counters, saturating at 16'hFFFF; when undefined, ports and counters absent, function otherwise identical.

Structure
REQ-030 Package mem_arb_pkg SHALL hold NUM_REQ=2, ADDR_W=32, CNT_W=16 and typedef req_t (valid, we, addr, wdata).
REQ-031 One sub-module rr_arb2 (2-way round-robin, pointer state) SHALL be instantiated twice, once per port.

Verification
REQ-032 Req0 write addr 5 data 16'hA5A5, then req0 read addr 5 -> rsp_valid[0] one cycle after read acceptance, rsp_rdata=16'hA5A5.
REQ-033 Both requesters read continuously after reset -> grants alternate 0,1,0,1; each rsp_valid matches its grant delayed one cycle.
REQ-034 Req0 reads addr 7 while req1 writes addr 7 data 16'h1234 in the same cycle -> both accepted; req0 gets old value; following read returns 16'h1234.
REQ-035 Req1 read addr 1024 (DEPTH_MEM=1024) -> rsp_valid[1]=1, rsp_err[1]=1, rsp_rdata=0; write addr 2000 -> mem_we stays 0.
REQ-036 Assert reset_n low the cycle after a read acceptance -> all outputs 0 immediately; no rsp_valid after release; pointers at 0.
REQ-037 With MEM_ARB_STATS_EN, 70000 req0 accepts -> grant_cnt[0]=16'hFFFF, grant_cnt[1]=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants, request bundle type and the 2-way round-robin pick used by mem_arb.
package mem_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int CNT_W   = 16;
  localparam int DATA_W  = 16;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Contention goes to the requester the pointer names; otherwise the sole requester wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
    if (&req) return ptr ? 2'b10 : 2'b01;
    return req;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, 1-bit pointer that flips only on contention.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  assign o_gnt = rr_pick(i_req, r_ptr);

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_ptr <= 1'b0;
    else if (&i_req) r_ptr <= ~r_ptr;
  end

endmodule

// File: rtl/mem_arb.sv
// Two-requester arbiter onto a memory with independent read/write ports (read-first, latency 1).
// Optional MEM_ARB_STATS_EN adds saturating per-requester accept counters on grant_cnt.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int WID_MEM   = 16,
  parameter int DEPTH_MEM = 1024
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][WID_MEM-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [WID_MEM-1:0]             rsp_rdata,
  output logic [NUM_REQ-1:0]             rsp_err,
  output logic [ADDR_W-1:0]              mem_raddr,
  output logic [ADDR_W-1:0]              mem_waddr,
  output logic                           mem_we,
  output logic [WID_MEM-1:0]             mem_din,
  input  logic [WID_MEM-1:0]             mem_dout
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][CNT_W-1:0]  grant_cnt
`endif
);

  logic [1:0]        w_rd_req, w_wr_req, w_rd_arb, w_wr_arb, w_rd_gnt, w_wr_gnt;
  logic              w_rd_sel, w_wr_sel, w_rd_any, w_wr_any, w_rd_oor, w_wr_oor;
  logic [ADDR_W-1:0] w_rd_addr, w_wr_addr;
  logic [ADDR_W-1:0] r_raddr;
  logic [1:0]        r_rsp_valid, r_rd_err, r_wr_err;

  assign w_rd_req = req_valid & ~req_we;
  assign w_wr_req = req_valid &  req_we;

  rr_arb2 u_rd_arb (.clk(clk), .reset_n(reset_n), .i_req(w_rd_req), .o_gnt(w_rd_arb));
  rr_arb2 u_wr_arb (.clk(clk), .reset_n(reset_n), .i_req(w_wr_req), .o_gnt(w_wr_arb));

  // Grants are forced low while reset is held so nothing is accepted during reset.
  assign w_rd_gnt  = w_rd_arb & {2{reset_n}};
  assign w_wr_gnt  = w_wr_arb & {2{reset_n}};
  assign req_ready = w_rd_gnt | w_wr_gnt;

  assign w_rd_sel  = w_rd_gnt[1];
  assign w_wr_sel  = w_wr_gnt[1];
  assign w_rd_any  = |w_rd_gnt;
  assign w_wr_any  = |w_wr_gnt;
  assign w_rd_addr = req_addr[w_rd_sel];
  assign w_wr_addr = req_addr[w_wr_sel];
  assign w_rd_oor  = w_rd_addr >= ADDR_W'(DEPTH_MEM);
  assign w_wr_oor  = w_wr_addr >= ADDR_W'(DEPTH_MEM);

  assign mem_raddr = w_rd_any ? w_rd_addr : r_raddr;
  assign mem_we    = w_wr_any & ~w_wr_oor;
  assign mem_waddr = w_wr_any ? w_wr_addr : '0;
  assign mem_din   = w_wr_any ? req_wdata[w_wr_sel] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_raddr     <= '0;
      r_rsp_valid <= '0;
      r_rd_err    <= '0;
      r_wr_err    <= '0;
    end else begin
      if (w_rd_any) r_raddr <= w_rd_addr;
      r_rsp_valid <= w_rd_gnt;
      r_rd_err    <= w_rd_gnt & {2{w_rd_oor}};
      r_wr_err    <= w_wr_gnt & {2{w_wr_oor}};
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rd_err | r_wr_err;
  assign rsp_rdata = (|r_rsp_valid && !(|r_rd_err)) ? mem_dout : '0;

`ifdef MEM_ARB_STATS_EN
  logic [NUM_REQ-1:0][CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (req_ready[i] && req_valid[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  end

  assign grant_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: reference arbiter/memory model feeds a response scoreboard.
module tb_mem_arb;
  import mem_arb_pkg::*;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       req_valid, req_ready, req_we;
  logic [1:0][31:0] req_addr;
  logic [1:0][15:0] req_wdata;
  logic [1:0]       rsp_valid, rsp_err;
  logic [15:0]      rsp_rdata;
  logic [31:0]      mem_raddr, mem_waddr;
  logic             mem_we;
  logic [15:0]      mem_din;
  logic [15:0]      mem_dout;
`ifdef MEM_ARB_STATS_EN
  logic [1:0][15:0] grant_cnt;
`endif

  int total = 0;
  int bad   = 0;

  mem_arb #(.WID_MEM(16), .DEPTH_MEM(1024)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_we(mem_we),
    .mem_din(mem_din), .mem_dout(mem_dout)
`ifdef MEM_ARB_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory attached to the DUT; out-of-range reads return a marker the DUT must hide.
  logic [15:0] tb_mem [0:1023];
  always @(posedge clk) begin
    if (mem_we && mem_waddr < 32'd1024) tb_mem[mem_waddr[9:0]] <= mem_din;
    mem_dout <= (mem_raddr < 32'd1024) ? tb_mem[mem_raddr[9:0]] : 16'hDEAD;
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [1:0]  v;
    logic [1:0]  err;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] shadow [0:1023];
  logic        m_prd, m_pwr;
  logic [31:0] m_hold;
  logic [1:0]  rq, wq, rg, wg;
  int          ri, wi;
  logic [31:0] e_raddr, e_waddr;
  logic        e_we;
  logic [15:0] e_din;
  exp_t        e_cur, e_new;

  function automatic logic [1:0] m_pick(input logic [1:0] r, input logic p);
    if (r == 2'b11) return p ? 2'b10 : 2'b01;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
      m_prd = 1'b0; m_pwr = 1'b0; m_hold = '0;
      total++;
      if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_err !== 2'b00 || rsp_rdata !== 16'h0 ||
          mem_we !== 1'b0 || mem_raddr !== 32'h0 || mem_waddr !== 32'h0 || mem_din !== 16'h0) begin
        bad++;
        $display("FAIL reset_outputs: ready=%b rv=%b err=%b rdata=%h we=%b ra=%h wa=%h din=%h, all must be 0",
                 req_ready, rsp_valid, rsp_err, rsp_rdata, mem_we, mem_raddr, mem_waddr, mem_din);
      end
    end else begin
      e_cur = '{v: 2'b00, err: 2'b00, data: 16'h0};
      if (sb.size() > 0) e_cur = sb.pop_front();
      total++;
      if (rsp_valid !== e_cur.v || rsp_err !== e_cur.err || rsp_rdata !== e_cur.data) begin
        bad++;
        $display("FAIL sb_response: got v=%b err=%b data=%h exp v=%b err=%b data=%h",
                 rsp_valid, rsp_err, rsp_rdata, e_cur.v, e_cur.err, e_cur.data);
      end

      rq = req_valid & ~req_we;
      wq = req_valid &  req_we;
      rg = m_pick(rq, m_prd);
      wg = m_pick(wq, m_pwr);
      ri = rg[1] ? 1 : 0;
      wi = wg[1] ? 1 : 0;
      e_raddr = (|rg) ? req_addr[ri] : m_hold;
      e_we    = (|wg) && (req_addr[wi] < 32'd1024);
      e_waddr = (|wg) ? req_addr[wi] : 32'h0;
      e_din   = (|wg) ? req_wdata[wi] : 16'h0;

      total++;
      if (req_ready !== (rg | wg) || mem_raddr !== e_raddr || mem_we !== e_we ||
          mem_waddr !== e_waddr || mem_din !== e_din) begin
        bad++;
        $display("FAIL sb_request: got ready=%b ra=%h we=%b wa=%h din=%h exp ready=%b ra=%h we=%b wa=%h din=%h",
                 req_ready, mem_raddr, mem_we, mem_waddr, mem_din, rg | wg, e_raddr, e_we, e_waddr, e_din);
      end

      e_new.v    = rg;
      e_new.err  = (rg & {2{req_addr[ri] >= 32'd1024}}) | (wg & {2{req_addr[wi] >= 32'd1024}});
      e_new.data = ((|rg) && req_addr[ri] < 32'd1024) ? shadow[req_addr[ri][9:0]] : 16'h0;
      sb.push_back(e_new);

      if (e_we) shadow[req_addr[wi][9:0]] = req_wdata[wi];
      if (|rg) m_hold = req_addr[ri];
      if (rq == 2'b11) m_prd = ~m_prd;
      if (wq == 2'b11) m_pwr = ~m_pwr;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic req_t rd(input logic [31:0] a);
    return '{valid: 1'b1, we: 1'b0, addr: a, wdata: 16'h0};
  endfunction

  function automatic req_t wr(input logic [31:0] a, input logic [15:0] d);
    return '{valid: 1'b1, we: 1'b1, addr: a, wdata: d};
  endfunction

  function automatic req_t idle();
    return '{valid: 1'b0, we: 1'b0, addr: 32'h0, wdata: 16'h0};
  endfunction

  task automatic put(input int i, input req_t r);
    req_valid[i] = r.valid;
    req_we[i]    = r.we;
    req_addr[i]  = r.addr;
    req_wdata[i] = r.wdata;
  endtask

  task automatic cyc(input req_t r0, input req_t r1);
    @(posedge clk); #1;
    put(0, r0);
    put(1, r1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    put(0, idle()); put(1, idle());
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    total++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || mem_we !== 1'b0 || mem_raddr !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: ready=%b rv=%b we=%b ra=%h exp 0", req_ready, rsp_valid, mem_we, mem_raddr);
    end
    do_reset();
  endtask

  task automatic test_write_read();
    cyc(wr(32'd5, 16'hA5A5), idle());
    cyc(rd(32'd5), idle());
    @(negedge clk);
    total++;
    if (req_ready !== 2'b01) begin
      bad++; $display("FAIL wr_rd_accept: ready=%b exp 01", req_ready);
    end
    cyc(idle(), idle());
    @(negedge clk);
    total++;
    if (rsp_valid !== 2'b01 || rsp_rdata !== 16'hA5A5) begin
      bad++; $display("FAIL wr_rd_data: v=%b data=%h exp v=01 data=a5a5", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k < 4) cyc(rd(32'd5), rd(32'd1023));
      else       cyc(idle(), idle());
      @(negedge clk);
      if (k < 4) begin
        total++;
        if (req_ready !== exp_g[k]) begin
          bad++; $display("FAIL alt_grant%0d: ready=%b exp %b", k, req_ready, exp_g[k]);
        end
      end
      if (k > 0) begin
        total++;
        if (rsp_valid !== exp_g[k-1]) begin
          bad++; $display("FAIL alt_rsp%0d: v=%b exp %b", k, rsp_valid, exp_g[k-1]);
        end
      end
    end
  endtask

  task automatic test_read_first();
    cyc(idle(), wr(32'd7, 16'h5555));
    cyc(rd(32'd7), wr(32'd7, 16'h1234));
    @(negedge clk);
    total++;
    if (req_ready !== 2'b11) begin
      bad++; $display("FAIL rf_accept: ready=%b exp 11", req_ready);
    end
    cyc(rd(32'd7), idle());
    @(negedge clk);
    total++;
    if (rsp_valid !== 2'b01 || rsp_rdata !== 16'h5555) begin
      bad++; $display("FAIL rf_old: v=%b data=%h exp v=01 data=5555", rsp_valid, rsp_rdata);
    end
    cyc(idle(), idle());
    @(negedge clk);
    total++;
    if (rsp_valid !== 2'b01 || rsp_rdata !== 16'h1234) begin
      bad++; $display("FAIL rf_new: v=%b data=%h exp v=01 data=1234", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_out_of_range();
    cyc(wr(32'd2000, 16'hBEEF), rd(32'd1024));
    @(negedge clk);
    total++;
    if (mem_we !== 1'b0 || req_ready !== 2'b11) begin
      bad++; $display("FAIL oor_we: we=%b ready=%b exp we=0 ready=11", mem_we, req_ready);
    end
    cyc(wr(32'd1023, 16'h0F0F), rd(32'd1023));
    @(negedge clk);
    total++;
    if (rsp_valid !== 2'b10 || rsp_err !== 2'b11 || rsp_rdata !== 16'h0) begin
      bad++; $display("FAIL oor_rsp: v=%b err=%b data=%h exp v=10 err=11 data=0", rsp_valid, rsp_err, rsp_rdata);
    end
    total++;
    if (mem_we !== 1'b1 || mem_waddr !== 32'd1023) begin
      bad++; $display("FAIL edge_we: we=%b wa=%h exp we=1 wa=3ff", mem_we, mem_waddr);
    end
    cyc(idle(), idle());
    @(negedge clk);
    total++;
    if (rsp_valid !== 2'b10 || rsp_err !== 2'b00) begin
      bad++; $display("FAIL edge_rsp: v=%b err=%b exp v=10 err=00", rsp_valid, rsp_err);
    end
  endtask

  task automatic test_reset_mid();
    cyc(rd(32'd5), idle());
    @(posedge clk); #1;
    put(0, idle()); put(1, rd(32'd5));
    reset_n = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 2'b00 || rsp_rdata !== 16'h0 || rsp_err !== 2'b00 || req_ready !== 2'b00) begin
      bad++; $display("FAIL rst_mid: v=%b data=%h err=%b ready=%b exp 0", rsp_valid, rsp_rdata, rsp_err, req_ready);
    end
    @(posedge clk); #1;
    put(1, idle());
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 2'b00) begin
        bad++; $display("FAIL rst_norsp%0d: v=%b exp 00", k, rsp_valid);
      end
    end
    cyc(rd(32'd1), rd(32'd2));
    @(negedge clk);
    total++;
    if (req_ready !== 2'b01) begin
      bad++; $display("FAIL rst_rdptr: ready=%b exp 01", req_ready);
    end
    cyc(wr(32'd3, 16'h0003), wr(32'd4, 16'h0004));
    @(negedge clk);
    total++;
    if (req_ready !== 2'b01) begin
      bad++; $display("FAIL rst_wrptr: ready=%b exp 01", req_ready);
    end
    cyc(idle(), idle());
  endtask

  function automatic logic [31:0] pick_addr();
    int s;
    s = $urandom_range(0, 19);
    if (s == 16) return 32'd1023;
    if (s == 17) return 32'd1024;
    if (s >= 18) return 32'd5000;
    return 32'(s);
  endfunction

  task automatic test_random();
    req_t r [2];
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 3) == 0) r[i] = idle();
        else if ($urandom_range(0, 1) == 0) r[i] = rd(pick_addr());
        else r[i] = wr(pick_addr(), 16'($urandom));
      end
      cyc(r[0], r[1]);
    end
    cyc(idle(), idle());
    @(negedge clk);
  endtask

`ifdef MEM_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    @(negedge clk);
    total++;
    if (grant_cnt[0] !== 16'h0 || grant_cnt[1] !== 16'h0) begin
      bad++; $display("FAIL cnt_reset: c0=%h c1=%h exp 0", grant_cnt[0], grant_cnt[1]);
    end
    cyc(rd(32'd9), idle());
    repeat (69999) @(posedge clk);
    #1 put(0, idle());
    @(negedge clk);
    total++;
    if (grant_cnt[0] !== 16'hFFFF || grant_cnt[1] !== 16'h0) begin
      bad++; $display("FAIL cnt_sat: c0=%h c1=%h exp c0=ffff c1=0", grant_cnt[0], grant_cnt[1]);
    end
  endtask
`endif

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int a = 0; a < 1024; a++) begin
      tb_mem[a] = 16'h0;
      shadow[a] = 16'h0;
    end
    test_reset();
    test_write_read();
    test_alternate();
    test_read_first();
    test_out_of_range();
    test_reset_mid();
    test_random();
`ifdef MEM_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
